imem_responder: RTL
===================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder: the slave end of the fetch bus driven by IF
//   (o_imem_stb/o_iaddr out, i_inst/i_imem_ack in). Holds a word-addressed
//   instruction store and returns one 32-bit word per request after LATENCY
//   wait cycles. Supports request abort on redirect and a side load port for
//   programme preload.
// PARAMETERS
//   DEPTH_WORDS  1024          instruction words stored; power of two, >= 2
//   LATENCY      1             wait cycles from request accept to ack; 1..15
//   NOP_INSTR    32'h00000013  word returned on error (ADDI x0,x0,0)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   i_imem_stb   in   1   fetch request; held with i_iaddr stable until ack
//   i_iaddr      in   32  byte address of fetch
//   i_flush      in   1   abort any pending request (branch/jump redirect)
//   o_inst       out  32  fetched instruction, valid when o_imem_ack=1
//   o_imem_ack   out  1   one-cycle completion pulse
//   o_imem_err   out  1   error flag qualified by o_imem_ack
//   o_busy       out  1   request accepted and not yet acked
//   i_load_we    in   1   preload write enable
//   i_load_addr  in   32  preload byte address (bits [1:0] ignored)
//   i_load_data  in   32  preload data
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, wait counter=0, o_imem_ack=0,
//     o_imem_err=0, o_busy=0, o_inst=32'h0. Memory contents not reset.
//   - FSM: IDLE -> WAIT -> ACK -> IDLE.
//     IDLE: stb=1 & flush=0 at edge -> capture word index i_iaddr[31:2] and
//       err flags; counter <= LATENCY-1; go WAIT. stb=0 or flush=1 -> stay.
//     WAIT: flush=1 -> IDLE, no ack ever issued for that request.
//       counter!=0 -> decrement. counter==0 -> read array at captured index
//       into o_inst, go ACK.
//     ACK: o_imem_ack=1 for exactly this cycle; always -> IDLE next edge.
//       stb still high in ACK belongs to the completing request; a new
//       request is accepted no earlier than the following IDLE cycle.
//   - Latency: stb first high in cycle N (state IDLE) -> ack in cycle
//     N+LATENCY+1. Throughput one word per LATENCY+2 cycles.
//   - o_busy=1 in WAIT and ACK.
//   - Errors (latched at accept, reported with ack): i_iaddr[1:0]!=0
//     (misaligned) or i_iaddr[31:2] >= DEPTH_WORDS (out of range) ->
//     o_imem_err=1 and o_inst=NOP_INSTR. Else o_imem_err=0.
//   - Flush in ACK cycle ignored (ack still issued). Flush and stb together
//     in IDLE: no accept.
//   - Load port: write array[i_load_addr[$clog2(DEPTH_WORDS)+1:2]] in any
//     state; upper out-of-range bits dropped silently. Write to the index
//     being read in the same edge as the WAIT read -> old data returned.
//     Writes before that edge are visible to the pending read.
//   - Reset mid-request: request lost, no ack after rst_n rises.
//   - Array read is synchronous (one registered read); no combinational path
//     from i_iaddr to o_inst.
// TESTING
//   1 LATENCY=1, preload [0x0]=0x00106293, stb=1 addr=0x0 -> ack 2 cycles
//     after stb, o_inst=0x00106293, err=0, ack high exactly 1 cycle.
//   2 LATENCY=3, back-to-back fetches 0x0,0x4,0x8 with stb held -> 3 acks,
//     each 5 cycles apart, data match preload; o_busy high WAIT..ACK.
//   3 stb addr=0x2 -> ack with err=1, o_inst=0x00000013; addr=4*DEPTH_WORDS
//     -> same error response.
//   4 LATENCY=3, flush one cycle after accept -> no ack; next stb addr=0xC
//     acked normally with [0xC] data.
//   5 load write to pending index: before read edge -> new data; on read
//     edge -> old data.
//   6 rst_n pulsed low during WAIT -> outputs 0 immediately (async), no
//     stray ack after release; fresh request completes correctly.

Source files
------------

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Slave end of the instruction-fetch bus. Holds a word-addressed instruction
//   store and answers each accepted fetch with one 32-bit word after LATENCY
//   wait cycles. Misaligned or out-of-range fetches are answered with a NOP
//   and the error flag. A pending fetch can be abandoned with i_flush, and a
//   side load port writes the store at any time for programme preload.
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_imem_stb,
    input  logic [31:0] i_iaddr,
    input  logic        i_flush,
    output logic [31:0] o_inst,
    output logic        o_imem_ack,
    output logic        o_imem_err,
    output logic        o_busy,
    input  logic        i_load_we,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // A fetch is bad if it is not word aligned or its word index lies past
    // the end of the store.
    function automatic logic fetch_addr_err(input logic [31:0] addr);
        logic misaligned_v;
        logic out_of_range_v;
        misaligned_v   = (addr[1:0] != 2'b00);
        out_of_range_v = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        fetch_addr_err = misaligned_v | out_of_range_v;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              accept_s;
    logic              read_s;
    logic [3:0]        cnt_r;
    logic [IDX_W-1:0]  req_idx_r;
    logic              req_err_r;
    logic [IDX_W-1:0]  load_idx_s;
    logic [31:0]       mem_r [DEPTH_WORDS];
    logic [31:0]       inst_r;
    logic              ack_r;
    logic              err_r;
    logic              busy_r;
    logic              unused_load_bits_s;

    // Only the in-range word index of the load address selects a location;
    // the remaining address bits are deliberately discarded.
    assign load_idx_s         = i_load_addr[IDX_W+1:2];
    assign unused_load_bits_s = ^{i_load_addr[31:IDX_W+2], i_load_addr[1:0]};

    // Next-state decode: accept in IDLE, count down or abort in WAIT, and
    // always return to IDLE one cycle after ACK.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        read_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_imem_stb && !i_flush) begin
                    state_next_s = ST_WAIT;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_flush) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_next_s = ST_ACK;
                    read_s       = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter: loaded at accept, decremented while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'(LATENCY - 1);
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Capture the request at accept so later address changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_idx_r <= '0;
            req_err_r <= 1'b0;
        end else if (accept_s) begin
            req_idx_r <= i_iaddr[IDX_W+1:2];
            req_err_r <= fetch_addr_err(i_iaddr);
        end else begin
            req_idx_r <= req_idx_r;
            req_err_r <= req_err_r;
        end
    end

    // Instruction store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_load_we) begin
            mem_r[load_idx_s] <= i_load_data;
        end
    end

    // Registered read and response flags; a same-edge load write is not yet
    // visible here, so the read returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= 32'h0000_0000;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            if (read_s) begin
                inst_r <= req_err_r ? NOP_INSTR : mem_r[req_idx_r];
            end else begin
                inst_r <= inst_r;
            end
            ack_r  <= (state_next_s == ST_ACK);
            err_r  <= read_s & req_err_r;
            busy_r <= (state_next_s == ST_WAIT) || (state_next_s == ST_ACK);
        end
    end

    assign o_inst     = inst_r;
    assign o_imem_ack = ack_r;
    assign o_imem_err = err_r;
    assign o_busy     = busy_r;

endmodule
